stage_sequencer: RTL and testbench
==================================

Name: stage_sequencer

Overview:
- Generalised, parametrised front-panel stage controller for the calculator datapath.
- Two raw push-buttons step the design through NUM_STAGES ordered stages (operand entry, operation select, result display, ...). Debouncing and press-edge detection are built in.
- A downstream "advance permitted" gate and a synchronous home input are added, plus optional wrap-around.
- Outputs a binary stage index, a one-hot stage vector and a stage-entry strobe. Datapath enables are decoded from these outside the block.

Parameters:
- NUM_STAGES, 4, number of stages; legal range 2..16.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles needed to accept a button level change; minimum 1.
- WRAP, 0, 1 = next from last stage goes to stage 0 and prev from stage 0 goes to last stage; 0 = saturate at both ends.
- IDX_W, $clog2(NUM_STAGES), width of stage_idx; derived, must not be overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- prev_button  input  1  raw, asynchronous, bouncy "previous stage" button; 1 = pressed.
- next_button  input  1  raw, asynchronous, bouncy "next stage" button; 1 = pressed.
- home  input  1  synchronous level; 1 = return to stage 0.
- advance_ok  input  1  synchronous level from the datapath; 0 blocks forward steps (e.g. operand not yet entered).
- stage_idx  output  IDX_W  current stage, binary.
- stage_onehot  output  NUM_STAGES  bit[stage_idx] = 1, all other bits 0.
- stage_enter  output  1  one-cycle strobe, high in the first cycle of any newly entered stage.
- at_first  output  1  stage_idx == 0.
- at_last  output  1  stage_idx == NUM_STAGES-1.

Behaviour:
- Reset (reset_n = 0 at an edge) sets:
  - stage_idx = 0, stage_onehot = 1, stage_enter = 0, at_first = 1, at_last = 0;
  - synchroniser flops, debounced levels, delayed debounced levels and debounce counters = 0.
- Reset has priority over every other input. Asserting it mid-debounce or mid-step discards all pending events.
- Per button, the debounce path is:
  - 2-flop synchroniser;
  - a counter that increments on each edge where the synchronised value differs from the debounced level, and clears to 0 on any edge where they match;
  - when the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears on that same edge.
- Press event = debounced level 1 and its one-cycle-delayed copy 0. Release produces no event.
- Latency: raw level first sampled high at edge k produces these changes (if all step conditions are met):
  - debounced level rises at edge k+1+DEBOUNCE_CYCLES;
  - stage_idx changes at edge k+2+DEBOUNCE_CYCLES.
- A bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no event.
- A button held through reset release is debounced from scratch and produces one press event.
- Step decision is evaluated once per edge, in this priority order:
  1. home = 1: if stage_idx != 0, go to stage 0; otherwise no change. Press events in that cycle are dropped.
  2. Prev and next press events in the same cycle: both ignored, no change.
  3. Next press: stage_idx+1 if advance_ok = 1 and not at last stage.
     - At last stage with WRAP = 1: go to 0.
     - At last stage with WRAP = 0: no change.
     - advance_ok = 0: event dropped, not queued.
  4. Prev press: stage_idx-1 if not at stage 0. At stage 0 with WRAP = 1: go to NUM_STAGES-1; otherwise no change. advance_ok does not gate prev.
- stage_enter is registered and high for exactly the cycle in which stage_idx first shows a changed value. It is never asserted when stage_idx does not change (saturation, blocked advance, home at stage 0).
- stage_onehot, at_first and at_last are driven combinationally from the stage_idx register. They are always consistent with stage_idx in the same cycle.
- stage_idx never holds a value >= NUM_STAGES, including when NUM_STAGES is not a power of two.
- A held button produces exactly one step; there is no auto-repeat.

Test Plan:
- Defaults with DEBOUNCE_CYCLES=4: clean next_button pulse held 10 cycles, advance_ok=1 -> stage_idx 0->1 at 7th edge after first high sample; stage_enter high one cycle; stage_onehot=4'b0010.
- next_button toggling every 2 cycles for 20 cycles, then low -> no stage change, stage_enter never asserted.
- WRAP=0, four clean next presses -> stage_idx 1,2,3,3; at_last=1; only three stage_enter pulses. Repeat with WRAP=1 -> fourth press gives 0, at_first=1.
- At stage 1 with advance_ok=0, next press -> stay at 1. Then prev press -> stage 0 with stage_enter.
- Both buttons pressed with identical timing -> no change. At stage 2, assert home in the press-event cycle -> stage 0, one stage_enter.
- NUM_STAGES=5, WRAP=1, prev from stage 0 -> stage 4. Assert reset_n=0 mid-debounce of next -> stage 0 held; held button yields one step after release.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Front-panel stage bundle: raw buttons and datapath gates in, stage state out.
// The master side is the panel/datapath; the slave side is the sequencer.
interface stage_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                  prev_button;
  logic                  next_button;
  logic                  home;
  logic                  advance_ok;
  logic [IDX_W-1:0]      stage_idx;
  logic [NUM_STAGES-1:0] stage_onehot;
  logic                  stage_enter;
  logic                  at_first;
  logic                  at_last;

  modport master (
    output prev_button, next_button, home, advance_ok,
    input  stage_idx, stage_onehot, stage_enter, at_first, at_last
  );

  modport slave (
    input  prev_button, next_button, home, advance_ok,
    output stage_idx, stage_onehot, stage_enter, at_first, at_last
  );
endinterface

// File: rtl/stage_sequencer.sv
// Button-driven stage sequencer: per-button debounce with press-edge detect,
// then a prioritised step decision (home > both > next > prev) on a stage register.
module stage_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic press
);
  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             db_q;
  logic             db_d_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      db_d_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], raw};
      db_d_q <= db_q;
      // The edge on which the count would reach DEBOUNCE_CYCLES is the toggle edge.
      if (sync_q[1] != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= ~db_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press = db_q & ~db_d_q;
endmodule

module stage_sequencer #(
  parameter  int NUM_STAGES      = 4,
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int WRAP            = 0,
  localparam int IDX_W           = $clog2(NUM_STAGES)
) (
  input  logic              clk,
  input  logic              reset_n,
  stage_sequencer_if.slave  sif
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

  // Bit 0 = prev, bit 1 = next.
  logic [1:0] raw_btn;
  logic [1:0] press;

  assign raw_btn = {sif.next_button, sif.prev_button};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    stage_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (raw_btn[i]),
      .press   (press[i])
    );
  end

  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             enter_q;

  always_comb begin
    idx_d = idx_q;
    if (sif.home) begin
      idx_d = '0;
    end else if (press[0] && press[1]) begin
      idx_d = idx_q;
    end else if (press[1]) begin
      // Blocked advances are dropped outright, never queued.
      if (sif.advance_ok) begin
        if (idx_q == LAST) idx_d = (WRAP != 0) ? '0 : idx_q;
        else               idx_d = idx_q + IDX_W'(1);
      end
    end else if (press[0]) begin
      if (idx_q == '0) idx_d = (WRAP != 0) ? LAST : idx_q;
      else             idx_d = idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q   <= '0;
      enter_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      enter_q <= (idx_d != idx_q);
    end
  end

  assign sif.stage_idx    = idx_q;
  assign sif.stage_enter  = enter_q;
  assign sif.stage_onehot = {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx_q;
  assign sif.at_first     = (idx_q == '0);
  assign sif.at_last      = (idx_q == LAST);
endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: three configurations driven in lockstep and checked
// every cycle against a stage model, plus directed scenario checks.
module tb_stage_sequencer;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic prev_b = 1'b0, next_b = 1'b0, home = 1'b0, adv = 1'b1;

  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(4)) if0 ();
  stage_sequencer_if #(.NUM_STAGES(4)) if1 ();
  stage_sequencer_if #(.NUM_STAGES(5)) if2 ();

  assign if0.prev_button = prev_b; assign if0.next_button = next_b;
  assign if0.home = home;          assign if0.advance_ok = adv;
  assign if1.prev_button = prev_b; assign if1.next_button = next_b;
  assign if1.home = home;          assign if1.advance_ok = adv;
  assign if2.prev_button = prev_b; assign if2.next_button = next_b;
  assign if2.home = home;          assign if2.advance_ok = adv;

  stage_sequencer #(.NUM_STAGES(4), .DEBOUNCE_CYCLES(DB), .WRAP(0)) u_d0 (.clk(clk), .reset_n(rst_n), .sif(if0));
  stage_sequencer #(.NUM_STAGES(4), .DEBOUNCE_CYCLES(DB), .WRAP(1)) u_d1 (.clk(clk), .reset_n(rst_n), .sif(if1));
  stage_sequencer #(.NUM_STAGES(5), .DEBOUNCE_CYCLES(DB), .WRAP(1)) u_d2 (.clk(clk), .reset_n(rst_n), .sif(if2));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-config stage number plus a shared button debouncer.
  int m_n[3]    = '{4, 4, 5};
  int m_wrap[3] = '{0, 1, 1};
  int m_idx[3]  = '{0, 0, 0};
  bit m_en[3]   = '{0, 0, 0};
  bit sy0[2] = '{0, 0}, sy1[2] = '{0, 0}, lvl[2] = '{0, 0}, lvl_d[2] = '{0, 0};
  int run_len[2] = '{0, 0};
  int en_cnt[3]  = '{0, 0, 0};

  function automatic logic [12:0] exp_vec(int c);
    logic [4:0] oh;
    oh = 5'd1 << m_idx[c];
    return {5'(m_idx[c]), oh, m_en[c], m_idx[c] == 0, m_idx[c] == m_n[c] - 1};
  endfunction

  task automatic cycle();
    bit ev_p, ev_n, s;
    int nw;
    bit raw[2];
    logic [12:0] obs[3];
    raw[0] = prev_b; raw[1] = next_b;
    @(posedge clk);
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin m_idx[c] = 0; m_en[c] = 0; end
      for (int b = 0; b < 2; b++) begin
        sy0[b] = 0; sy1[b] = 0; lvl[b] = 0; lvl_d[b] = 0; run_len[b] = 0;
      end
    end else begin
      ev_p = lvl[0] && !lvl_d[0];
      ev_n = lvl[1] && !lvl_d[1];
      for (int c = 0; c < 3; c++) begin
        nw = m_idx[c];
        if (home) nw = 0;
        else if (ev_p && ev_n) nw = m_idx[c];
        else if (ev_n) begin
          if (adv) begin
            if (m_idx[c] == m_n[c] - 1) nw = m_wrap[c] ? 0 : m_idx[c];
            else nw = m_idx[c] + 1;
          end
        end else if (ev_p) begin
          if (m_idx[c] == 0) nw = m_wrap[c] ? m_n[c] - 1 : 0;
          else nw = m_idx[c] - 1;
        end
        m_en[c] = (nw != m_idx[c]);
        m_idx[c] = nw;
      end
      for (int b = 0; b < 2; b++) begin
        lvl_d[b] = lvl[b];
        s = sy1[b];
        if (s != lvl[b]) begin
          run_len[b]++;
          if (run_len[b] == DB) begin lvl[b] = !lvl[b]; run_len[b] = 0; end
        end else run_len[b] = 0;
        sy1[b] = sy0[b];
        sy0[b] = raw[b];
      end
    end
    @(negedge clk);
    obs[0] = {5'(if0.stage_idx), 5'(if0.stage_onehot), if0.stage_enter, if0.at_first, if0.at_last};
    obs[1] = {5'(if1.stage_idx), 5'(if1.stage_onehot), if1.stage_enter, if1.at_first, if1.at_last};
    obs[2] = {5'(if2.stage_idx), if2.stage_onehot, if2.stage_enter, if2.at_first, if2.at_last};
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (obs[c] !== exp_vec(c)) begin
        miscompares++;
        $display("FAIL model_dut%0d t=%0t got idx/oh/en/f/l=%b required %b", c, $time, obs[c], exp_vec(c));
      end
      if (obs[c][2] === 1'b1) en_cnt[c]++;
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic clear_en();
    for (int c = 0; c < 3; c++) en_cnt[c] = 0;
  endtask

  task automatic press_next(int hold, int gap);
    next_b = 1'b1; run(hold); next_b = 1'b0; run(gap);
  endtask

  task automatic press_prev(int hold, int gap);
    prev_b = 1'b1; run(hold); prev_b = 1'b0; run(gap);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run(2); rst_n = 1'b1; run(2); clear_en();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; prev_b = 1'b0; next_b = 1'b0; home = 1'b0; adv = 1'b1;
    run(3);
    vectors++;
    if ({if0.stage_idx, if0.stage_onehot, if0.stage_enter, if0.at_first, if0.at_last} !== {2'd0, 4'b0001, 1'b0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state got idx=%0d oh=%b en=%b f=%b l=%b required 0 0001 0 1 0",
               if0.stage_idx, if0.stage_onehot, if0.stage_enter, if0.at_first, if0.at_last);
    end
    rst_n = 1'b1; run(2);
  endtask

  task automatic test_clean_press();
    int hit = 0;
    bit oh_ok = 1'b0;
    clear_en();
    next_b = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      if (hit == 0 && if0.stage_idx == 2'd1) begin
        hit = e;
        oh_ok = (if0.stage_onehot === 4'b0010) && (if0.stage_enter === 1'b1);
      end
    end
    next_b = 1'b0; run(10);
    vectors++;
    if (hit != 7) begin
      miscompares++;
      $display("FAIL press_latency got edge %0d required 7", hit);
    end
    vectors++;
    if (!oh_ok || en_cnt[0] != 1) begin
      miscompares++;
      $display("FAIL press_outputs got oh_ok=%b enters=%0d required 1 and 1", oh_ok, en_cnt[0]);
    end
  endtask

  task automatic test_bounce();
    clear_en();
    for (int i = 0; i < 10; i++) begin
      next_b = ~next_b; run(2);
    end
    next_b = 1'b0; run(12);
    vectors++;
    if (if0.stage_idx !== 2'd1 || en_cnt[0] != 0) begin
      miscompares++;
      $display("FAIL bounce got idx=%0d enters=%0d required 1 and 0", if0.stage_idx, en_cnt[0]);
    end
  endtask

  task automatic test_saturate_wrap();
    int exp0[4] = '{1, 2, 3, 3};
    int exp1[4] = '{1, 2, 3, 0};
    do_reset();
    for (int p = 0; p < 4; p++) begin
      press_next(10, 10);
      vectors++;
      if (int'(if0.stage_idx) != exp0[p] || int'(if1.stage_idx) != exp1[p]) begin
        miscompares++;
        $display("FAIL saturate_wrap press %0d got %0d/%0d required %0d/%0d",
                 p, if0.stage_idx, if1.stage_idx, exp0[p], exp1[p]);
      end
    end
    vectors++;
    if (if0.at_last !== 1'b1 || en_cnt[0] != 3 || if1.at_first !== 1'b1 || en_cnt[1] != 4) begin
      miscompares++;
      $display("FAIL saturate_flags got last0=%b enters0=%0d first1=%b enters1=%0d required 1 3 1 4",
               if0.at_last, en_cnt[0], if1.at_first, en_cnt[1]);
    end
  endtask

  task automatic test_advance_block();
    do_reset();
    press_next(10, 10);
    adv = 1'b0; clear_en();
    press_next(10, 10);
    vectors++;
    if (if0.stage_idx !== 2'd1 || en_cnt[0] != 0) begin
      miscompares++;
      $display("FAIL advance_block got idx=%0d enters=%0d required 1 and 0", if0.stage_idx, en_cnt[0]);
    end
    press_prev(10, 10);
    adv = 1'b1;
    vectors++;
    if (if0.stage_idx !== 2'd0 || en_cnt[0] != 1) begin
      miscompares++;
      $display("FAIL prev_unblocked got idx=%0d enters=%0d required 0 and 1", if0.stage_idx, en_cnt[0]);
    end
  endtask

  task automatic test_both_home();
    do_reset();
    prev_b = 1'b1; next_b = 1'b1; run(10);
    prev_b = 1'b0; next_b = 1'b0; run(10);
    vectors++;
    if (if0.stage_idx !== 2'd0 || if1.stage_idx !== 2'd0 || en_cnt[1] != 0) begin
      miscompares++;
      $display("FAIL both_pressed got %0d/%0d enters=%0d required 0/0 and 0", if0.stage_idx, if1.stage_idx, en_cnt[1]);
    end
    press_next(10, 10);
    press_next(10, 10);
    clear_en();
    next_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      home = (i == 6);
      cycle();
    end
    home = 1'b0; next_b = 1'b0; run(10);
    vectors++;
    if (if0.stage_idx !== 2'd0 || en_cnt[0] != 1) begin
      miscompares++;
      $display("FAIL home_in_event got idx=%0d enters=%0d required 0 and 1", if0.stage_idx, en_cnt[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    press_prev(10, 10);
    vectors++;
    if (if2.stage_idx !== 3'd4 || if0.stage_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL prev_wrap5 got %0d (dut0 %0d) required 4 (0)", if2.stage_idx, if0.stage_idx);
    end
    next_b = 1'b1; run(3);
    rst_n = 1'b0; run(2);
    vectors++;
    if (if2.stage_idx !== 3'd0 || if0.stage_idx !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_mid_hold got %0d/%0d required 0/0", if2.stage_idx, if0.stage_idx);
    end
    rst_n = 1'b1; clear_en();
    run(14);
    vectors++;
    if (if0.stage_idx !== 2'd1 || en_cnt[0] != 1 || if2.stage_idx !== 3'd1) begin
      miscompares++;
      $display("FAIL held_through_reset got %0d/%0d enters=%0d required 1/1 and 1",
               if0.stage_idx, if2.stage_idx, en_cnt[0]);
    end
    next_b = 1'b0; run(10);
  endtask

  task automatic test_random();
    do_reset();
    for (int s = 0; s < 160; s++) begin
      prev_b = ($urandom_range(0, 3) == 0);
      next_b = ($urandom_range(0, 2) == 0);
      adv    = ($urandom_range(0, 4) != 0);
      home   = ($urandom_range(0, 25) == 0);
      rst_n  = ($urandom_range(0, 50) != 0);
      run($urandom_range(1, 14));
      home = 1'b0; rst_n = 1'b1;
    end
    prev_b = 1'b0; next_b = 1'b0; adv = 1'b1;
    run(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_saturate_wrap();
    test_advance_block();
    test_both_home();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
